hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_scoreboard.sv | 46 ++++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Build option: HAZARD_FWD_EN selects the forwarding variant of hazard_ctrl.
package hazard_pkg;

  localparam int REG_SEL_W = 3;
  localparam logic [REG_SEL_W-1:0] LINK_REG = 3'd7;

  // EX operand source codes
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // One in-flight instruction: does it exist, does it write, is it a load, which register
  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic                 ld;
    logic [REG_SEL_W-1:0] sel;
  } sb_entry_t;

  // Youngest producer wins: the instruction now in EX beats the one in MEM
  function automatic logic [1:0] fwd_pick(input logic m_ex, input logic m_mem);
    if (m_ex) return FWD_EXMEM;
    if (m_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight write tracker: entry 0 is the instruction in EX, entry 1 the one in MEM.
// Shifts every cycle unless held; a bubble inserts an empty entry at the head.
// Also reports, per entry, whether it produces a register the ID instruction reads.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 insert_bubble,
  input  sb_entry_t            new_entry,
  input  logic [REG_SEL_W-1:0] rs_sel,
  input  logic                 rs_use,
  input  logic [REG_SEL_W-1:0] rt_sel,
  input  logic                 rt_use,
  output logic [DEPTH-1:0]     rs_match,
  output logic [DEPTH-1:0]     rt_match,
  output logic                 ex_is_load
);

  sb_entry_t sb_q [DEPTH];

  // Shift register: hold on freeze, otherwise admit the new entry or a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else if (!hold) begin
      sb_q[0] <= insert_bubble ? '0 : new_entry;
      for (int i = 1; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // Per-entry producer/consumer match for both read ports
  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int j = 0; j < DEPTH; j++) begin
      rs_match[j] = sb_q[j].valid & sb_q[j].wr & rs_use & (sb_q[j].sel == rs_sel);
      rt_match[j] = sb_q[j].valid & sb_q[j].wr & rt_use & (sb_q[j].sel == rt_sel);
    end
    ex_is_load = sb_q[0].valid & sb_q[0].ld;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW hazard stall, branch flush, memory freeze.
// Per-cycle priority: rst > mem_busy > ex_br_taken > data hazard.
// Build option HAZARD_FWD_EN: only load-use stalls, and EX operand forwarding
// selects are produced; without it every RAW dependency stalls and fwd_* stay 00.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_SEL_W-1:0] id_rs_sel,
  input  logic                 id_rs_use,
  input  logic [REG_SEL_W-1:0] id_rt_sel,
  input  logic                 id_rt_use,
  input  logic                 id_wr_en,
  input  logic [REG_SEL_W-1:0] id_wr_sel,
  input  logic                 id_is_load,
  input  logic                 ex_br_taken,
  input  logic                 mem_busy,
  output logic                 stall_pc,
  output logic                 bubble_ex,
  output logic                 flush_ifid,
  output logic                 freeze_all,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_W-1:0]     stall_cnt
);

`ifdef HAZARD_FWD_EN
  localparam bit LOAD_USE_ONLY = 1'b1;
`else
  localparam bit LOAD_USE_ONLY = 1'b0;
`endif

  logic [DEPTH-1:0] rs_match;
  logic [DEPTH-1:0] rt_match;
  logic [DEPTH-1:0] hit;
  logic             ex_is_load;
  logic             haz;
  logic             stall_go;

  hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .hold          (mem_busy),
    .insert_bubble (ex_br_taken | haz),
    .new_entry     ({id_valid, id_wr_en, id_is_load, id_wr_sel}),
    .rs_sel        (id_rs_sel),
    .rs_use        (id_rs_use),
    .rt_sel        (id_rt_sel),
    .rt_use        (id_rt_use),
    .rs_match      (rs_match),
    .rt_match      (rt_match),
    .ex_is_load    (ex_is_load)
  );

  // Hazard detection and prioritised pipe controls; all controls are zero in reset
  always_comb begin
    hit        = rs_match | rt_match;
    haz        = id_valid & (LOAD_USE_ONLY ? (hit[0] & ex_is_load) : (|hit));
    stall_go   = !rst & !mem_busy & !ex_br_taken & haz;
    stall_pc   = stall_go;
    flush_ifid = !rst & !mem_busy & ex_br_taken;
    bubble_ex  = stall_go | flush_ifid;
    freeze_all = !rst & mem_busy;
  end

  // Saturating count of cycles lost to data-hazard stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_go && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef HAZARD_FWD_EN
  // Operand sources captured as ID advances into EX; a bubble carries no forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!mem_busy) begin
      if (ex_br_taken || haz || !id_valid) begin
        fwd_a <= FWD_RF;
        fwd_b <= FWD_RF;
      end else begin
        fwd_a <= fwd_pick(rs_match[0], rs_match[1]);
        fwd_b <= fwd_pick(rt_match[0], rt_match[1]);
      end
    end
  end
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked every
// cycle against an instruction-level pipeline model through an expected queue.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 4;
  localparam int DEPTH = 2;
  localparam int OUT_W = 8 + CNT_W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, id_valid, id_rs_use, id_rt_use, id_wr_en, id_is_load;
  logic [2:0]       id_rs_sel, id_rt_sel, id_wr_sel;
  logic             ex_br_taken, mem_busy;
  logic             stall_pc, bubble_ex, flush_ifid, freeze_all;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_use(id_rs_use),
    .id_rt_sel(id_rt_sel), .id_rt_use(id_rt_use),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
    .freeze_all(freeze_all), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       valid;
    logic       rs_use;
    logic [2:0] rs;
    logic       rt_use;
    logic [2:0] rt;
    logic       wr;
    logic [2:0] wd;
    logic       ld;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [2:0] rd;
  } inflight_t;

  instr_t           cur;
  instr_t           prog_q[$];
  inflight_t        pipe_q[$];   // [0] = in EX, [1] = in MEM
  logic [1:0]       m_fwd_a, m_fwd_b;
  logic [CNT_W-1:0] m_cnt;

  logic [OUT_W-1:0] exp_q[$];
  logic             chk_en;
  int               checks = 0;
  int               errors = 0;

  function automatic instr_t mk_alu(input logic [2:0] rd, input logic [2:0] rs,
                                    input logic [2:0] rt, input logic rs_u, input logic rt_u);
    instr_t i;
    i = '{valid: 1'b1, rs_use: rs_u, rs: rs, rt_use: rt_u, rt: rt, wr: 1'b1, wd: rd, ld: 1'b0};
    return i;
  endfunction

  function automatic instr_t mk_ld(input logic [2:0] rd, input logic [2:0] base);
    instr_t i;
    i = '{valid: 1'b1, rs_use: 1'b1, rs: base, rt_use: 1'b0, rt: 3'd0, wr: 1'b1, wd: rd, ld: 1'b1};
    return i;
  endfunction

  function automatic bit reads_from(input inflight_t p, input logic u, input logic [2:0] r);
    return p.valid && p.wr && u && (p.rd == r);
  endfunction

  // Would the instruction in ID have to wait for an older one still in flight?
  function automatic bit model_haz(input instr_t i);
    if (!i.valid) return 1'b0;
    if (FWD)
      return pipe_q[0].ld && (reads_from(pipe_q[0], i.rs_use, i.rs) ||
                              reads_from(pipe_q[0], i.rt_use, i.rt));
    for (int j = 0; j < DEPTH; j++)
      if (reads_from(pipe_q[j], i.rs_use, i.rs) || reads_from(pipe_q[j], i.rt_use, i.rt))
        return 1'b1;
    return 1'b0;
  endfunction

  // Where an operand comes from once the instruction reaches EX (nearest producer)
  function automatic logic [1:0] model_src(input logic u, input logic [2:0] r);
    if (!FWD) return 2'b00;
    if (reads_from(pipe_q[0], u, r)) return 2'b01;
    if (reads_from(pipe_q[1], u, r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    for (int j = 0; j < DEPTH; j++) pipe_q.push_back('0);
    m_fwd_a = 2'b00;
    m_fwd_b = 2'b00;
    m_cnt   = '0;
    cur     = '0;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle and records what must come out
  task automatic step(input logic br, input logic mb, input logic r);
    bit haz;
    logic e_stall, e_bub, e_flush, e_frz;
    rst = r; ex_br_taken = br; mem_busy = mb;
    id_valid = cur.valid; id_rs_use = cur.rs_use; id_rs_sel = cur.rs;
    id_rt_use = cur.rt_use; id_rt_sel = cur.rt; id_wr_en = cur.wr;
    id_wr_sel = cur.wd; id_is_load = cur.ld;
    chk_en = 1'b1;
    haz     = model_haz(cur);
    e_stall = !r && !mb && !br && haz;
    e_flush = !r && !mb && br;
    e_bub   = e_stall || e_flush;
    e_frz   = !r && mb;
    exp_q.push_back({e_stall, e_bub, e_flush, e_frz, m_fwd_a, m_fwd_b, m_cnt});
    if (r) begin
      model_reset();
    end else if (!mb) begin
      if (br || haz) begin
        pipe_q.push_front('0);
        void'(pipe_q.pop_back());
        m_fwd_a = 2'b00;
        m_fwd_b = 2'b00;
        if (!br && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (br) cur = '0;
      end else begin
        m_fwd_a = cur.valid ? model_src(cur.rs_use, cur.rs) : 2'b00;
        m_fwd_b = cur.valid ? model_src(cur.rt_use, cur.rt) : 2'b00;
        pipe_q.push_front('{valid: cur.valid, wr: cur.wr, ld: cur.ld, rd: cur.wd});
        void'(pipe_q.pop_back());
        cur = (prog_q.size() > 0) ? prog_q.pop_front() : '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp);
    checks++;
    if (stall_cnt !== exp) begin
      errors++;
      $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, exp);
    end
  endtask

  task automatic check_fwd_a(input string name, input logic [1:0] exp);
    checks++;
    if (fwd_a !== exp) begin
      errors++;
      $display("FAIL %s: fwd_a got %b expected %b", name, fwd_a, exp);
    end
  endtask

  function automatic logic [2:0] rand_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? LINK_REG : 3'(v);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [OUT_W-1:0] mon_exp, mon_got;
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      mon_got = {stall_pc, bubble_ex, flush_ifid, freeze_all, fwd_a, fwd_b, stall_cnt};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cycle_outputs: no expected entry, got %h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL cycle_outputs @%0t: {stall,bub,flush,frz,fa,fb,cnt} got %b expected %b",
                   $time, mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    chk_en = 1'b0;
    rst = 1'b1; ex_br_taken = 1'b0; mem_busy = 1'b0;
    id_valid = 1'b0; id_rs_use = 1'b0; id_rt_use = 1'b0; id_wr_en = 1'b0;
    id_is_load = 1'b0; id_rs_sel = '0; id_rt_sel = '0; id_wr_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cnt("reset_cnt", '0);

    // Back-to-back ALU dependency
    prog_q.push_back(mk_alu(3'd1, 3'd2, 3'd3, 1, 1));
    prog_q.push_back(mk_alu(3'd2, 3'd1, 3'd3, 1, 1));
    run(7);
    check_cnt("alu_b2b", FWD ? 4'd0 : 4'd2);

    // Dependency one instruction apart, then the same with the read port unused
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_alu(3'd4, 3'd1, 3'd2, 1, 1));
    prog_q.push_back(mk_alu(3'd5, 3'd1, 3'd2, 1, 1));
    prog_q.push_back(mk_alu(3'd6, 3'd4, 3'd3, 1, 1));
    run(7);
    check_cnt("one_apart", FWD ? 4'd0 : 4'd1);
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_alu(3'd4, 3'd1, 3'd2, 1, 1));
    prog_q.push_back(mk_alu(3'd5, 3'd1, 3'd2, 1, 1));
    prog_q.push_back(mk_alu(3'd6, 3'd4, 3'd3, 0, 1));
    run(7);
    check_cnt("unused_port", 4'd0);

    // Branch resolves while the ID instruction is waiting on a load
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_ld(3'd1, 3'd2));
    prog_q.push_back(mk_alu(3'd2, 3'd1, 3'd3, 1, 1));
    run(2);
    step(1'b1, 1'b0, 1'b0);
    run(4);
    check_cnt("flush_mid_stall", 4'd0);

    // Memory freeze in the middle of a stall
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_ld(3'd1, 3'd2));
    prog_q.push_back(mk_alu(3'd2, 3'd1, 3'd3, 1, 1));
    run(3);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    run(4);
    check_cnt("freeze_stall", FWD ? 4'd1 : 4'd2);

    // Load-use into both operands, then ALU-to-ALU
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_ld(3'd5, 3'd1));
    prog_q.push_back(mk_alu(3'd6, 3'd5, 3'd5, 1, 1));
    run(4);
    check_fwd_a("load_use_fwd", FWD ? 2'b10 : 2'b00);
    run(3);
    check_cnt("load_use_cnt", FWD ? 4'd1 : 4'd2);
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_alu(3'd3, 3'd1, 3'd2, 1, 1));
    prog_q.push_back(mk_alu(3'd4, 3'd3, 3'd1, 1, 1));
    run(3);
    check_fwd_a("alu_fwd", FWD ? 2'b01 : 2'b00);
    run(3);

    // Reset in the middle of a stall
    step(1'b0, 1'b0, 1'b1);
    prog_q.push_back(mk_ld(3'd1, 3'd2));
    prog_q.push_back(mk_alu(3'd2, 3'd1, 3'd3, 1, 1));
    run(3);
    check_cnt("pre_reset", 4'd1);
    step(1'b0, 1'b0, 1'b1);
    check_cnt("post_reset", 4'd0);
    run(3);

    // Drive the counter into saturation
    for (int p = 0; p < 20; p++) begin
      prog_q.push_back(mk_ld(3'd1, 3'd2));
      prog_q.push_back(mk_alu(3'd2, 3'd1, 3'd3, 1, 1));
    end
    run(90);
    check_cnt("saturated", 4'hF);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      instr_t ri;
      if (prog_q.size() < 4) begin
        ri = mk_alu(rand_reg(), rand_reg(), rand_reg(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        ri.valid = ($urandom_range(0, 9) != 0);
        ri.wr    = ($urandom_range(0, 4) != 0);
        ri.ld    = ($urandom_range(0, 2) == 0);
        prog_q.push_back(ri);
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    chk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
